// File: rtl/fifo_rptr_empty_pkg.sv
// Shared FIFO package: default geometry and threshold used by both the read-side
// and write-side pointer blocks.
//   FIFO_ADDR_SIZE : log2 of FIFO depth; pointers are FIFO_ADDR_SIZE+1 bits wide
//   FIFO_AE_THRESH : almost_empty asserts when the read-side level is <= this value
package fifo_rptr_empty_pkg;

    localparam int unsigned FIFO_ADDR_SIZE = 4;
    localparam int unsigned FIFO_AE_THRESH = 2;

endpackage

// File: rtl/bin_to_gray.sv
// Binary to reflected-Gray conversion (purely combinational).
//   bin  : binary input
//   gray : Gray-coded output
module bin_to_gray #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_to_bin.sv
// Reflected-Gray to binary conversion (purely combinational).
//   gray : Gray-coded input
//   bin  : binary output
module gray_to_bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
// Shared with the write-side pointer block.
//   clk   : destination-domain clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input, captured directly by stage1 with no logic in front
//   q     : stage2 output, safe to use in the clk domain
module sync_2ff #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty/level logic of an asynchronous FIFO.
//   clk             : read-domain clock
//   rst_n           : asynchronous active-low reset (deassertion synchronized externally)
//   rd_en           : read request
//   wptr_gray_async : Gray write pointer from the write clock domain
//   rptr_gray       : registered Gray read pointer, exported to the write side
//   raddr           : RAM read address (low ADDR_SIZE bits of the binary read pointer)
//   rd_fire         : accepted read, rd_en & ~empty
//   empty           : registered empty flag
//   almost_empty    : registered, high when rd_level <= AE_THRESH
//   rd_level        : registered occupancy as seen by the read side, 0..2^ADDR_SIZE
module fifo_rptr_empty
    import fifo_rptr_empty_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = FIFO_ADDR_SIZE,
    parameter int unsigned AE_THRESH = FIFO_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE:0]   wptr_gray_async,
    output logic [ADDR_SIZE:0]   rptr_gray,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic                 rd_fire,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   rd_level
);

    localparam int unsigned PW = ADDR_SIZE + 1;

    logic [PW-1:0] wsync_gray;
    logic [PW-1:0] wsync_bin;
    logic [PW-1:0] rbin_q;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_q;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] level_q;
    logic [PW-1:0] level_next;
    logic          empty_q;
    logic          almost_empty_q;

    sync_2ff #(
        .WIDTH (PW)
    ) u_wptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wptr_gray_async),
        .q     (wsync_gray)
    );

    gray_to_bin #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray (wsync_gray),
        .bin  (wsync_bin)
    );

    bin_to_gray #(
        .WIDTH (PW)
    ) u_rptr_b2g (
        .bin  (rbin_next),
        .gray (rgray_next)
    );

    assign rd_fire   = rd_en & ~empty_q;
    assign rbin_next = rbin_q + PW'(rd_fire);

    // Level and empty are computed against the post-read pointer, so reading the
    // last entry raises empty on the same edge that consumes it.
    assign level_next = wsync_bin - rbin_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin_q         <= '0;
            rgray_q        <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            rbin_q         <= rbin_next;
            rgray_q        <= rgray_next;
            level_q        <= level_next;
            empty_q        <= (rgray_next == wsync_gray);
            almost_empty_q <= (32'(level_next) <= AE_THRESH);
        end
    end

    assign rptr_gray    = rgray_q;
    assign raddr        = rbin_q[ADDR_SIZE-1:0];
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign rd_level     = level_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty: directed vector table, a mid-burst
// reset sequence, and a randomized run against a count-based occupancy model.
module tb_fifo_rptr_empty;

    localparam int unsigned AS = 4;
    localparam int unsigned AE = 2;

    logic       clk;
    logic       rst_n;
    logic       rd_en;
    logic [4:0] wptr_gray_async;
    logic [4:0] rptr_gray;
    logic [3:0] raddr;
    logic       rd_fire;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;

    int checks;
    int failures;

    fifo_rptr_empty #(
        .ADDR_SIZE (AS),
        .AE_THRESH (AE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_en           (rd_en),
        .wptr_gray_async (wptr_gray_async),
        .rptr_gray       (rptr_gray),
        .raddr           (raddr),
        .rd_fire         (rd_fire),
        .empty           (empty),
        .almost_empty    (almost_empty),
        .rd_level        (rd_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       rd_en;
        logic [4:0] wbin;
        logic       exp_fire;   // before the edge
        logic [3:0] exp_raddr;  // before the edge
        logic       exp_empty;  // after the edge
        logic [4:0] exp_level;
        logic       exp_ae;
        logic [4:0] exp_rbin;
    } vec_t;

    vec_t vecs [20];

    // Random-phase model: write/read counts and the write count seen two edges late
    int   w;
    int   m_r;
    int   m_s1;
    int   m_s2;
    int   m_level;
    logic m_empty;
    logic exp_fire;
    int   step;
    int   dut_fires;
    logic [4:0] prev_gray;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        rd_en     = 1'b0;
        wptr_gray_async = '0;

        //            rst rd  wbin fire raddr empty level ae rbin
        vecs[0]  = '{1'b0, 1'b1, 5'd0,  1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[1]  = '{1'b1, 1'b0, 5'd3,  1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[2]  = '{1'b1, 1'b1, 5'd3,  1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[3]  = '{1'b1, 1'b1, 5'd3,  1'b0, 4'd0, 1'b0, 5'd3,  1'b0, 5'd0};
        vecs[4]  = '{1'b1, 1'b1, 5'd3,  1'b1, 4'd0, 1'b0, 5'd2,  1'b1, 5'd1};
        vecs[5]  = '{1'b1, 1'b1, 5'd3,  1'b1, 4'd1, 1'b0, 5'd1,  1'b1, 5'd2};
        vecs[6]  = '{1'b1, 1'b1, 5'd3,  1'b1, 4'd2, 1'b1, 5'd0,  1'b1, 5'd3};
        vecs[7]  = '{1'b1, 1'b1, 5'd3,  1'b0, 4'd3, 1'b1, 5'd0,  1'b1, 5'd3};
        vecs[8]  = '{1'b1, 1'b1, 5'd3,  1'b0, 4'd3, 1'b1, 5'd0,  1'b1, 5'd3};
        vecs[9]  = '{1'b1, 1'b0, 5'd19, 1'b0, 4'd3, 1'b1, 5'd0,  1'b1, 5'd3};
        vecs[10] = '{1'b1, 1'b0, 5'd19, 1'b0, 4'd3, 1'b1, 5'd0,  1'b1, 5'd3};
        vecs[11] = '{1'b1, 1'b0, 5'd19, 1'b0, 4'd3, 1'b0, 5'd16, 1'b0, 5'd3};
        vecs[12] = '{1'b0, 1'b1, 5'd19, 1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[13] = '{1'b1, 1'b0, 5'd16, 1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[14] = '{1'b1, 1'b0, 5'd16, 1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[15] = '{1'b1, 1'b0, 5'd16, 1'b0, 4'd0, 1'b0, 5'd16, 1'b0, 5'd0};
        vecs[16] = '{1'b0, 1'b0, 5'd0,  1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[17] = '{1'b1, 1'b0, 5'd1,  1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[18] = '{1'b1, 1'b0, 5'd1,  1'b0, 4'd0, 1'b1, 5'd0,  1'b1, 5'd0};
        vecs[19] = '{1'b1, 1'b0, 5'd1,  1'b0, 4'd0, 1'b0, 5'd1,  1'b1, 5'd0};

        // ---------------- directed table ----------------
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            rst_n           = vecs[i].rst_n;
            rd_en           = vecs[i].rd_en;
            wptr_gray_async = g(vecs[i].wbin);
            #1;
            chk($sformatf("vec%0d rd_fire", i), 32'(rd_fire), 32'(vecs[i].exp_fire));
            chk($sformatf("vec%0d raddr_pre", i), 32'(raddr), 32'(vecs[i].exp_raddr));
            @(negedge clk);
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d rd_level", i), 32'(rd_level), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].exp_ae));
            chk($sformatf("vec%0d rptr_gray", i), 32'(rptr_gray), 32'(g(vecs[i].exp_rbin)));
            chk($sformatf("vec%0d raddr", i), 32'(raddr), 32'(vecs[i].exp_rbin[3:0]));
        end

        // ---------------- mid-burst reset ----------------
        // State here: rbin=0, one entry visible. Bring level to 8, read 3 -> level 5.
        rd_en = 1'b0;
        wptr_gray_async = g(5'd8);
        repeat (3) @(negedge clk);
        chk("pre_burst level", 32'(rd_level), 32'd8);
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("burst level", 32'(rd_level), 32'd5);
        chk("burst raddr", 32'(raddr), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst empty", 32'(empty), 32'd1);
        chk("midrst almost_empty", 32'(almost_empty), 32'd1);
        chk("midrst rd_level", 32'(rd_level), 32'd0);
        chk("midrst rptr_gray", 32'(rptr_gray), 32'd0);
        chk("midrst raddr", 32'(raddr), 32'd0);
        chk("midrst rd_fire", 32'(rd_fire), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Pointer is still 8, but it has to be resynchronized before any read.
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post_rst fire%0d", i), 32'(rd_fire), (i == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // ---------------- randomized run vs model ----------------
        rst_n = 1'b0;
        rd_en = 1'b0;
        wptr_gray_async = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        w         = 0;
        m_r       = 0;
        m_s1      = 0;
        m_s2      = 0;
        m_level   = 0;
        m_empty   = 1'b1;
        dut_fires = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            rd_en = (cyc < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0) begin
                step = int'($urandom_range(0, 2));
                if (w + step - m_r > 16) step = 16 - (w - m_r);
                w += step;
            end
            wptr_gray_async = g(5'(w));
            #1;
            exp_fire = rd_en && !m_empty;
            chk("rnd rd_fire", 32'(rd_fire), 32'(exp_fire));
            chk("rnd raddr", 32'(raddr), 32'(m_r % 16));
            if (rd_fire === 1'b1) dut_fires++;
            prev_gray = rptr_gray;
            @(posedge clk);
            m_r     = m_r + (exp_fire ? 1 : 0);
            m_level = (m_s2 - m_r) & 31;
            m_empty = (m_level == 0);
            m_s2    = m_s1;
            m_s1    = w;
            @(negedge clk);
            chk("rnd empty", 32'(empty), 32'(m_empty));
            chk("rnd rd_level", 32'(rd_level), 32'(m_level));
            chk("rnd almost_empty", 32'(almost_empty), (m_level <= 2) ? 32'd1 : 32'd0);
            chk("rnd rptr_gray", 32'(rptr_gray), 32'(g(5'(m_r))));
            chk("rnd gray_step", 32'($countones(prev_gray ^ rptr_gray)), exp_fire ? 32'd1 : 32'd0);
        end
        chk("rnd fire_count", 32'(dut_fires), 32'(m_r));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
